// File: rtl/countdown_start_ctrl_pkg.sv
// Shared types and constants for the countdown start controller and other button users.
package countdown_start_ctrl_pkg;

  localparam int DIGIT_W             = 3;
  localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNTING = 2'd1,
    ST_RUN      = 2'd2
  } state_t;

  // Bits needed to hold any value 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/countdown_start_ctrl_if.sv
// Link between the start controller and the one-second clock driver / main FSM.
// The beep line exists only when CDS_BEEP_EN is defined.
interface countdown_start_ctrl_if;
  import countdown_start_ctrl_pkg::*;

  logic               count_finish;
  logic               flash;
  logic               count_enable;
  logic               go;
  logic               running;
  logic [DIGIT_W-1:0] digit;
  logic               led;
`ifdef CDS_BEEP_EN
  logic               beep;
`endif

  modport master (
    input  count_finish,
    input  flash,
    output count_enable,
    output go,
    output running,
    output digit,
    output led
`ifdef CDS_BEEP_EN
    , output beep
`endif
  );

  modport slave (
    output count_finish,
    output flash,
    input  count_enable,
    input  go,
    input  running,
    input  digit,
    input  led
`ifdef CDS_BEEP_EN
    , input beep
`endif
  );

endinterface

// File: rtl/countdown_start_ctrl_btn_debounce.sv
// Raw button -> 2-FF synchronizer -> stable-count debounce -> one-cycle press on accepted rise.
// Press appears 2 + DEBOUNCE_CYCLES cycles after a clean raw edge; holding never repeats.
module btn_debounce
  import countdown_start_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter tracks how long the synchronized input has disagreed with the
  // accepted level; any agreement (a bounce back) restarts the wait.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      press_d  = sync2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/countdown_start_ctrl.sv
// Start/abort control ahead of the one-second clock driver: countdown digit, go pulse, running flag.
// Defining CDS_BEEP_EN adds a beeper output driven from flash edges and the go event.
module countdown_start_ctrl
  import countdown_start_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int COUNT_START     = 4
`ifdef CDS_BEEP_EN
  , parameter int BEEP_CYCLES   = 5_000_000
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_btn,
  input  logic                  abort_btn,
  countdown_start_ctrl_if.master cds
);

  localparam logic [DIGIT_W-1:0] DIGIT_START = DIGIT_W'(COUNT_START);

  logic start_press;
  logic abort_press;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (start_btn),
    .press_o (start_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_abort_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (abort_btn),
    .press_o (abort_press)
  );

  state_t             state_q, state_d;
  logic [DIGIT_W-1:0] digit_q, digit_d;
  logic               flash_d_q;
  logic               go_q, go_d;
  logic               flash_edge;

  // flash_d_q follows flash every cycle, so the driver's own reset of flash
  // while disabled is already absorbed when COUNTING is entered.
  assign flash_edge = cds.flash ^ flash_d_q;

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    go_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        digit_d = '0;
        if (start_press && !abort_press) begin
          state_d = ST_COUNTING;
          digit_d = DIGIT_START;
        end
      end
      ST_COUNTING: begin
        if (abort_press) begin
          state_d = ST_IDLE;
          digit_d = '0;
        end else if (cds.count_finish) begin
          state_d = ST_RUN;
          digit_d = '0;
          go_d    = 1'b1;
        end else if (flash_edge && (digit_q != '0)) begin
          digit_d = digit_q - DIGIT_W'(1);
        end
      end
      ST_RUN: begin
        digit_d = '0;
        if (abort_press) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        digit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      digit_q   <= '0;
      flash_d_q <= 1'b0;
      go_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      flash_d_q <= cds.flash;
      go_q      <= go_d;
    end
  end

  // Driver-facing outputs decode straight from the state register so an
  // asynchronous reset drops them without waiting for a clock.
  assign cds.count_enable = (state_q == ST_COUNTING);
  assign cds.running      = (state_q == ST_RUN);
  assign cds.go           = go_q;
  assign cds.digit        = digit_q;
  assign cds.led          = (state_q == ST_RUN) | ((state_q == ST_COUNTING) & cds.flash);

`ifdef CDS_BEEP_EN
  localparam int            BW       = cnt_width(2 * BEEP_CYCLES);
  localparam logic [BW-1:0] BEEP_SEC = BW'(BEEP_CYCLES);
  localparam logic [BW-1:0] BEEP_GO  = BW'(2 * BEEP_CYCLES);

  logic          beep_tick;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;

  assign beep_tick = (state_q == ST_COUNTING) && !abort_press && !cds.count_finish && flash_edge;

  always_comb begin
    beep_cnt_d = beep_cnt_q;
    if (abort_press) begin
      beep_cnt_d = '0;
    end else if (go_d) begin
      beep_cnt_d = BEEP_GO;
    end else if (beep_tick) begin
      beep_cnt_d = BEEP_SEC;
    end else if (beep_cnt_q != '0) begin
      beep_cnt_d = beep_cnt_q - BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beep_cnt_q <= '0;
    end else begin
      beep_cnt_q <= beep_cnt_d;
    end
  end

  assign cds.beep = |beep_cnt_q;
`endif

endmodule

// File: tb/tb_countdown_start_ctrl.sv
// Directed and random stimulus for countdown_start_ctrl against a behavioural
// model of the block plus a behavioural one-second clock driver (10-cycle second).
module tb_countdown_start_ctrl;
  import countdown_start_ctrl_pkg::*;

  localparam int DEB    = 4;
  localparam int BEEP   = 3;
  localparam int CSTART = 4;
  localparam int SEC    = 10;
  localparam int M_IDLE = 0;
  localparam int M_CNT  = 1;
  localparam int M_RUN  = 2;

  logic clk       = 1'b0;
  logic rst_n     = 1'b1;
  logic start_btn = 1'b0;
  logic abort_btn = 1'b0;

  always #5 clk = ~clk;

  countdown_start_ctrl_if cds ();

  countdown_start_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .COUNT_START     (CSTART)
`ifdef CDS_BEEP_EN
    , .BEEP_CYCLES   (BEEP)
`endif
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_btn (start_btn),
    .abort_btn (abort_btn),
    .cds       (cds)
  );

  // Clock-driver model: counts seconds while enabled, toggles flash each
  // second, raises count_finish on the 4th tick, clears one cycle after disable.
  int   sec_cnt = 0;
  int   ticks   = 0;
  logic flash_r = 1'b0;
  logic fin_r   = 1'b0;

  always @(posedge clk) begin
    if (cds.count_enable !== 1'b1) begin
      sec_cnt <= 0;
      ticks   <= 0;
      flash_r <= 1'b0;
      fin_r   <= 1'b0;
    end else if (sec_cnt == SEC - 1) begin
      sec_cnt <= 0;
      ticks   <= ticks + 1;
      flash_r <= ~flash_r;
      if (ticks + 1 >= 4) fin_r <= 1'b1;
    end else begin
      sec_cnt <= sec_cnt + 1;
    end
  end

  assign cds.flash        = flash_r;
  assign cds.count_finish = fin_r;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int             m_mode, m_digit, m_beep;
  bit             m_go, m_fprev;
  bit [DEB+1:0]   h_start, h_abort;
  bit             acc_s, acc_a, pr_s, pr_a;
  bit             coincide_seen;
  int             press_seen;
  int             go_cnt;
  int             dseq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mode = M_IDLE; m_digit = 0; m_beep = 0; m_go = 0; m_fprev = 0;
    h_start = '0; h_abort = '0; acc_s = 0; acc_a = 0; pr_s = 0; pr_a = 0;
  endtask

  // A level is accepted once the 2-cycle-delayed raw input has disagreed with
  // the accepted level for DEB consecutive samples.
  task automatic deb_step(inout bit [DEB+1:0] h, inout bit acc, input bit raw, output bit press);
    bit all_diff;
    h = {h[DEB:0], raw};
    all_diff = 1'b1;
    for (int j = 2; j <= DEB + 1; j++) if (h[j] == acc) all_diff = 1'b0;
    press = 1'b0;
    if (all_diff) begin
      acc   = ~acc;
      press = acc;
    end
  endtask

  task automatic m_edge(input bit s_raw, input bit a_raw, input bit f, input bit cf);
    int  prev = m_mode;
    bit  sp   = pr_s;
    bit  ap   = pr_a;
    bit  fe   = (f != m_fprev);
    m_go = 1'b0;
    if (prev == M_IDLE) begin
      if (sp && !ap) begin m_mode = M_CNT; m_digit = CSTART; end
    end else if (prev == M_CNT) begin
      if (ap) begin
        m_mode = M_IDLE; m_digit = 0;
        if (cf) coincide_seen = 1'b1;
      end else if (cf) begin
        m_mode = M_RUN; m_digit = 0; m_go = 1'b1;
      end else if (fe && m_digit > 0) begin
        m_digit = m_digit - 1;
      end
    end else if (ap) begin
      m_mode = M_IDLE;
    end
    if (ap) m_beep = 0;
    else if (m_go) m_beep = 2 * BEEP;
    else if (prev == M_CNT && fe && !cf) m_beep = BEEP;
    else if (m_beep > 0) m_beep = m_beep - 1;
    m_fprev = f;
    deb_step(h_start, acc_s, s_raw, pr_s);
    deb_step(h_abort, acc_a, a_raw, pr_a);
  endtask

  // One clock: sample inputs before the edge, advance model, compare at negedge.
  task automatic tick();
    bit s_raw = start_btn;
    bit a_raw = abort_btn;
    bit f     = flash_r;
    bit cf    = fin_r;
    bit r     = rst_n;
    @(posedge clk);
    if (!r) m_reset();
    else m_edge(s_raw, a_raw, f, cf);
    @(negedge clk);
    if (u_dut.start_press === 1'b1) press_seen++;
    if (cds.go === 1'b1) go_cnt++;
    chk("count_enable", cds.count_enable, (m_mode == M_CNT));
    chk("go", cds.go, m_go);
    chk("running", cds.running, (m_mode == M_RUN));
    chk("digit", cds.digit, m_digit);
    chk("led", cds.led, (m_mode == M_CNT) ? flash_r : (m_mode == M_RUN));
`ifdef CDS_BEEP_EN
    chk("beep", cds.beep, (m_beep != 0));
`endif
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_count_enable"}, cds.count_enable, 0);
    chk({pfx, "_go"}, cds.go, 0);
    chk({pfx, "_running"}, cds.running, 0);
    chk({pfx, "_digit"}, cds.digit, 0);
    chk({pfx, "_led"}, cds.led, 0);
`ifdef CDS_BEEP_EN
    chk({pfx, "_beep"}, cds.beep, 0);
`endif
  endtask

  task automatic wait_ce(input int budget, output int lat);
    lat = 0;
    while (cds.count_enable !== 1'b1 && lat < budget) begin
      tick();
      lat++;
    end
    chk("ce_rise_in_budget", cds.count_enable, 1);
  endtask

  task automatic watch_run(input int budget);
    int last = cds.digit;
    dseq.delete();
    dseq.push_back(last);
    go_cnt = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (cds.digit != last) begin
        last = cds.digit;
        dseq.push_back(last);
      end
      if (cds.running === 1'b1) break;
    end
    chk("run_reached", cds.running, 1);
    tick();
    tick();
    chk("go_pulses", go_cnt, 1);
    chk("digit_steps", dseq.size(), CSTART + 1);
    for (int i = 0; i <= CSTART; i++)
      if (i < dseq.size()) chk("digit_seq", dseq[i], CSTART - i);
  endtask

  initial begin
    int lat;
    m_reset();
    coincide_seen = 1'b0;
    press_seen    = 0;
    go_cnt        = 0;

    // Reset state
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    tick();
    rst_n = 1'b1;
    repeat (5) tick();

    // Bouncy start press: exactly one press, enable 7 cycles after stable edge
    press_seen = 0;
    for (int i = 0; i < 10; i++) begin
      start_btn = ((i / 2) % 2) == 1;
      tick();
    end
    start_btn = 1'b1;
    wait_ce(50, lat);
    chk("start_latency", lat, 2 + DEB + 1);
    chk("start_digit", cds.digit, CSTART);
    repeat ($urandom_range(1, 4)) tick();
    chk("start_presses", press_seen, 1);

    // Full countdown to RUN
    start_btn = 1'b0;
    watch_run(80);

    // Abort from RUN
    abort_btn = 1'b1;
    repeat (DEB + 6) tick();
    chk("abort_run_running", cds.running, 0);
    abort_btn = 1'b0;
    repeat (10) tick();

    // Abort during second 2 of COUNTING, then a clean restart
    start_btn = 1'b1;
    wait_ce(30, lat);
    start_btn = 1'b0;
    repeat ($urandom_range(12, 20)) tick();
    abort_btn = 1'b1;
    go_cnt = 0;
    repeat (DEB + 8) tick();
    chk("abort_cnt_go", go_cnt, 0);
    chk("abort_cnt_ce", cds.count_enable, 0);
    chk("abort_cnt_digit", cds.digit, 0);
    abort_btn = 1'b0;
    repeat (10) tick();
    start_btn = 1'b1;
    wait_ce(30, lat);
    chk("restart_digit", cds.digit, CSTART);
    start_btn = 1'b0;
    watch_run(80);
    abort_btn = 1'b1;
    repeat (DEB + 6) tick();
    abort_btn = 1'b0;
    repeat (10) tick();

    // count_finish and abort_press land on the same cycle
    start_btn = 1'b1;
    wait_ce(30, lat);
    for (int i = 0; i < 4 * SEC - (DEB + 2); i++) begin
      if (i == 3) start_btn = 1'b0;
      tick();
    end
    abort_btn = 1'b1;
    go_cnt = 0;
    repeat (12) tick();
    chk("coincide_hit", coincide_seen, 1);
    chk("coincide_go", go_cnt, 0);
    chk("coincide_running", cds.running, 0);
    chk("coincide_ce", cds.count_enable, 0);
    abort_btn = 1'b0;
    repeat (10) tick();

    // Simultaneous start and abort in IDLE: stays IDLE
    start_btn = 1'b1;
    abort_btn = 1'b1;
    repeat (DEB + 8) tick();
    chk("both_idle_ce", cds.count_enable, 0);
    start_btn = 1'b0;
    abort_btn = 1'b0;
    repeat (10) tick();

    // Asynchronous reset mid-COUNTING
    start_btn = 1'b1;
    wait_ce(30, lat);
    start_btn = 1'b0;
    repeat ($urandom_range(8, 25)) tick();
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_counting");
    m_reset();
    @(negedge clk);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    start_btn = 1'b1;
    wait_ce(30, lat);
    chk("post_rst_latency", lat, 2 + DEB + 1);
    start_btn = 1'b0;
    watch_run(80);

    // Asynchronous reset mid-RUN
    repeat ($urandom_range(2, 9)) tick();
    #3 rst_n = 1'b0;
    #1 chk_zero("rst_run");
    m_reset();
    @(negedge clk);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    start_btn = 1'b1;
    wait_ce(30, lat);
    chk("post_rst_run_digit", cds.digit, CSTART);
    start_btn = 1'b0;
    watch_run(80);

    // Random button activity against the model
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 24) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 69) == 0) abort_btn = ~abort_btn;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not finish, vectors=%0d miscompares=%0d", n_vec, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
